// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM handshake state, arbiter FSM state and owner encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        RETRY = 2'd2
    } arb_state_t;

    // Encodings double as bit positions in the arbiter's active vector.
    typedef enum logic [1:0] {
        OWN_I = 2'd0,
        OWN_D = 2'd1,
        OWN_V = 2'd2
    } arb_owner_t;

    localparam int ERR_RETRY_DEFAULT = 2;

endpackage

// File: rtl/arb_pick.sv
// Combinational owner selection for mem_arbiter: fixed priority D > V > I, or round-robin
// D->V->I starting after the last completed owner when MEM_ARBITER_RR_EN is defined.
module arb_pick
    import cpu_types_pkg::*;
(
    input  logic [2:0] active,
    input  arb_owner_t last_owner,
    output arb_owner_t owner
);

`ifdef MEM_ARBITER_RR_EN
    always_comb begin
        owner = OWN_I;
        case (last_owner)
            OWN_D: begin
                if (active[OWN_V])      owner = OWN_V;
                else if (active[OWN_I]) owner = OWN_I;
                else if (active[OWN_D]) owner = OWN_D;
            end
            OWN_V: begin
                if (active[OWN_I])      owner = OWN_I;
                else if (active[OWN_D]) owner = OWN_D;
                else if (active[OWN_V]) owner = OWN_V;
            end
            default: begin
                if (active[OWN_D])      owner = OWN_D;
                else if (active[OWN_V]) owner = OWN_V;
                else if (active[OWN_I]) owner = OWN_I;
            end
        endcase
    end
`else
    logic unused_last;
    assign unused_last = ^last_owner;

    always_comb begin
        owner = OWN_I;
        if (active[OWN_D])      owner = OWN_D;
        else if (active[OWN_V]) owner = OWN_V;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Three-way (icache / dcache / vector) arbiter onto a single RAM port with ERROR retry.
// Define MEM_ARBITER_RR_EN for round-robin selection instead of fixed priority D > V > I.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ERR_RETRY = ERR_RETRY_DEFAULT
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    output logic      ierr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      derr,
    input  logic      vREN,
    input  logic      vWEN,
    input  word_t     vaddr,
    input  word_t     vstore,
    output word_t     vload,
    output logic      vwait,
    output logic      verr,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam int CNT_W = $clog2(ERR_RETRY + 2);

    arb_state_t       state_reg;
    arb_owner_t       owner_reg;
    arb_owner_t       last_owner_reg;
    arb_owner_t       pick_owner;
    logic [CNT_W-1:0] retry_cnt_reg;

    logic [2:0] active;
    logic [2:0] wait_vec;
    logic [2:0] err_vec;
    word_t      load_vec [3];

    logic  own_ren, own_wen, own_act;
    word_t own_addr, own_store;
    logic  in_xfer, ram_access, ram_fail, completing, retries_left;

    assign active = {vREN | vWEN, dREN | dWEN, iREN};

    arb_pick u_pick (
        .active     (active),
        .last_owner (last_owner_reg),
        .owner      (pick_owner)
    );

    always_comb begin
        own_ren   = iREN;
        own_wen   = 1'b0;
        own_addr  = iaddr;
        own_store = '0;
        case (owner_reg)
            OWN_D: begin
                own_ren   = dREN;
                own_wen   = dWEN;
                own_addr  = daddr;
                own_store = dstore;
            end
            OWN_V: begin
                own_ren   = vREN;
                own_wen   = vWEN;
                own_addr  = vaddr;
                own_store = vstore;
            end
            default: ;
        endcase
    end

    assign own_act      = own_ren | own_wen;
    assign in_xfer      = (state_reg == XFER);
    assign retries_left = (retry_cnt_reg < CNT_W'(ERR_RETRY));
    assign ram_access   = in_xfer & own_act & (ramstate == ACCESS);
    assign ram_fail     = in_xfer & own_act & (ramstate == ERROR) & ~retries_left;
    assign completing   = ram_access | ram_fail;

    // REN with WEN is a write, so the read strobe is masked by WEN.
    assign ramREN   = in_xfer & own_ren & ~own_wen;
    assign ramWEN   = in_xfer & own_wen;
    assign ramaddr  = in_xfer ? own_addr  : '0;
    assign ramstore = in_xfer ? own_store : '0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_req
        logic is_owner;
        assign is_owner     = in_xfer & (owner_reg == arb_owner_t'(gi));
        assign wait_vec[gi] = active[gi] & ~(is_owner & completing);
        assign err_vec[gi]  = is_owner & ram_fail;
        assign load_vec[gi] = (is_owner & ram_access) ? ramload : '0;
    end

    assign iwait = wait_vec[OWN_I];
    assign dwait = wait_vec[OWN_D];
    assign vwait = wait_vec[OWN_V];
    assign ierr  = err_vec[OWN_I];
    assign derr  = err_vec[OWN_D];
    assign verr  = err_vec[OWN_V];
    assign iload = load_vec[OWN_I];
    assign dload = load_vec[OWN_D];
    assign vload = load_vec[OWN_V];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            owner_reg      <= OWN_I;
            last_owner_reg <= OWN_I;
            retry_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|active) begin
                        owner_reg     <= pick_owner;
                        retry_cnt_reg <= '0;
                        state_reg     <= XFER;
                    end
                end
                XFER: begin
                    // An owner that drops its request aborts without touching last_owner.
                    if (!own_act) begin
                        state_reg <= IDLE;
                    end else if (ramstate == ACCESS) begin
                        state_reg      <= IDLE;
                        last_owner_reg <= owner_reg;
                    end else if (ramstate == ERROR) begin
                        if (retries_left) begin
                            retry_cnt_reg <= retry_cnt_reg + 1'b1;
                            state_reg     <= RETRY;
                        end else begin
                            state_reg      <= IDLE;
                            last_owner_reg <= owner_reg;
                        end
                    end
                end
                RETRY: state_reg <= own_act ? XFER : IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle checks plus a scoreboard of expected
// load data / granted addresses that is popped when the DUT completes.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN;
    word_t     iaddr, iload;
    logic      iwait, ierr;
    logic      dREN, dWEN;
    word_t     daddr, dstore, dload;
    logic      dwait, derr;
    logic      vREN, vWEN;
    word_t     vaddr, vstore, vload;
    logic      vwait, verr;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] sb_q [$];

    always #5 CLK = ~CLK;

    mem_arbiter #(.ERR_RETRY(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait), .ierr(ierr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload),
        .dwait(dwait), .derr(derr),
        .vREN(vREN), .vWEN(vWEN), .vaddr(vaddr), .vstore(vstore), .vload(vload),
        .vwait(vwait), .verr(verr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: got %08h expected scoreboard entry (queue empty)", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            chk(tag, obs, exp);
            $display("txn %s data=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 1'b0;
        iREN = 0; iaddr = '0;
        dREN = 0; dWEN = 0; daddr = '0; dstore = '0;
        vREN = 0; vWEN = 0; vaddr = '0; vstore = '0;
        ramload = '0; ramstate = FREE;
        #2;
        chk("rst ramREN", ramREN, 0);
        chk("rst ramWEN", ramWEN, 0);
        chk("rst derr",   derr, 0);
        chk("rst dload",  dload, 0);
        cyc(); nRST = 1'b1;
        smp(); chk("rst idle dwait", dwait, 0);

        // A: I and D together, D first after 2 BUSY, then I after one IDLE
        cyc(); iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h80;
        sb_q.push_back(32'h11112222); sb_q.push_back(32'h33334444);
        smp(); chk("A idle dwait", dwait, 1); chk("A idle ramREN", ramREN, 0);
        cyc(); ramstate = BUSY;
        smp(); chk("A ramREN", ramREN, 1); chk("A ramaddr", ramaddr, 32'h80);
        chk("A busy1 dwait", dwait, 1);
        cyc(); smp(); chk("A busy2 dwait", dwait, 1);
        cyc(); ramstate = ACCESS; ramload = 32'h11112222;
        smp(); chk("A done dwait", dwait, 0); chk_pop("A dload", dload);
        chk("A iwait held", iwait, 1);
        cyc(); dREN = 0; ramload = 32'h33334444;
        smp(); chk("A gap ramREN", ramREN, 0); chk("A gap iwait", iwait, 1);
        chk("A gap iload", iload, 0);
        cyc(); smp(); chk("A i ramaddr", ramaddr, 32'h40); chk("A iwait", iwait, 0);
        chk_pop("A iload", iload);
        cyc(); iREN = 0; ramstate = FREE; ramload = '0;

        // E: D aborts mid-XFER, I granted next
        cyc(); dREN = 1; daddr = 32'h84; iREN = 1; iaddr = 32'h44; ramstate = BUSY;
        sb_q.push_back(32'h55556666);
        smp(); chk("E idle ramREN", ramREN, 0);
        cyc(); smp(); chk("E ramaddr", ramaddr, 32'h84); chk("E ramREN", ramREN, 1);
        cyc(); dREN = 0;
        smp(); chk("E abort derr", derr, 0); chk("E abort dwait", dwait, 0);
        chk("E abort ramREN", ramREN, 0); chk("E abort iwait", iwait, 1);
        cyc(); smp(); chk("E idle2 ramREN", ramREN, 0); chk("E idle2 iwait", iwait, 1);
        cyc(); ramstate = ACCESS; ramload = 32'h55556666;
        smp(); chk("E i ramaddr", ramaddr, 32'h44); chk("E iwait", iwait, 0);
        chk_pop("E iload", iload);
        cyc(); iREN = 0; ramstate = FREE; ramload = '0;

        // B: vector write
        cyc(); vWEN = 1; vaddr = 32'h100; vstore = 32'hDEADBEEF;
        sb_q.push_back(32'h0BAD0BAD);
        smp(); chk("B idle vwait", vwait, 1); chk("B idle ramWEN", ramWEN, 0);
        cyc(); ramstate = BUSY;
        smp(); chk("B ramWEN", ramWEN, 1); chk("B ramREN", ramREN, 0);
        chk("B ramaddr", ramaddr, 32'h100); chk("B ramstore", ramstore, 32'hDEADBEEF);
        chk("B busy vwait", vwait, 1);
        cyc(); ramstate = ACCESS; ramload = 32'h0BAD0BAD;
        smp(); chk("B done vwait", vwait, 0); chk_pop("B vload", vload);
        cyc(); vWEN = 0; ramstate = FREE; ramload = '0;
        smp(); chk("B after ramWEN", ramWEN, 0);

        // C: three ERRORs with two RETRY cycles, final error pulse
        cyc(); dREN = 1; daddr = 32'h200;
        smp(); chk("C idle derr", derr, 0);
        cyc(); ramstate = ERROR;
        smp(); chk("C e1 ramREN", ramREN, 1); chk("C e1 dwait", dwait, 1); chk("C e1 derr", derr, 0);
        cyc(); ramstate = FREE;
        smp(); chk("C r1 ramREN", ramREN, 0); chk("C r1 dwait", dwait, 1);
        cyc(); ramstate = ERROR;
        smp(); chk("C e2 ramREN", ramREN, 1); chk("C e2 derr", derr, 0);
        cyc(); ramstate = FREE;
        smp(); chk("C r2 ramREN", ramREN, 0);
        cyc(); ramstate = ERROR;
        smp(); chk("C e3 derr", derr, 1); chk("C e3 dwait", dwait, 0);
        cyc(); dREN = 0; ramstate = FREE;
        smp(); chk("C post derr", derr, 0); chk("C post ramREN", ramREN, 0);

        // G: REN and WEN together is a write
        cyc(); dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'h5A5A5A5A;
        smp();
        cyc(); ramstate = ACCESS;
        smp(); chk("G ramWEN", ramWEN, 1); chk("G ramREN", ramREN, 0);
        chk("G ramstore", ramstore, 32'h5A5A5A5A); chk("G dwait", dwait, 0);
        cyc(); dREN = 0; dWEN = 0; ramstate = FREE;

        // D: reset mid-XFER
        cyc(); dREN = 1; daddr = 32'h400;
        sb_q.push_back(32'hCAFE0001);
        smp();
        cyc(); ramstate = BUSY;
        smp(); chk("D ramREN", ramREN, 1);
        #1 nRST = 1'b0;
        #1 chk("D rst ramREN", ramREN, 0); chk("D rst dwait", dwait, 1); chk("D rst derr", derr, 0);
        cyc(); nRST = 1'b1;
        smp(); chk("D rel ramREN", ramREN, 0); chk("D rel dwait", dwait, 1);
        cyc(); ramstate = ACCESS; ramload = 32'hCAFE0001;
        smp(); chk("D regrant ramREN", ramREN, 1); chk("D regrant dwait", dwait, 0);
        chk_pop("D dload", dload);
        cyc(); dREN = 0; ramstate = FREE; ramload = '0;

        // F: all three active continuously after a fresh reset
        cyc(); nRST = 1'b0;
        smp(); chk("F rst iwait", iwait, 0);
        cyc(); nRST = 1'b1;
        iREN = 1; iaddr = 32'h500; dREN = 1; daddr = 32'h600; vREN = 1; vaddr = 32'h700;
        ramstate = ACCESS;
`ifdef MEM_ARBITER_RR_EN
        sb_q.push_back(32'h600); sb_q.push_back(32'h700);
        sb_q.push_back(32'h500); sb_q.push_back(32'h600);
`else
        for (int k = 0; k < 4; k++) sb_q.push_back(32'h600);
`endif
        for (int k = 0; k < 4; k++) begin
            smp(); chk("F gap ramREN", ramREN, 0);
            cyc(); smp(); chk_pop("F grant ramaddr", ramaddr);
            cyc();
        end
        iREN = 0; dREN = 0; vREN = 0; ramstate = FREE;
        smp(); chk("sb empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ERR_RETRY, default 2: number of reissues after a ramstate ERROR before the access is failed.
REQ-002 SHALL have port CLK, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port nRST, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports iREN in 1, iaddr in 32 (word_t), iload out 32, iwait out 1, ierr out 1: icache fetch port.
REQ-005 SHALL have ports dREN in 1, dWEN in 1, daddr in 32, dstore in 32, dload out 32, dwait out 1, derr out 1: dcache port.
REQ-006 SHALL have ports vREN in 1, vWEN in 1, vaddr in 32, vstore in 32, vload out 32, vwait out 1, verr out 1: vector load/store port (VLW/VSW/VLWO/VSWO).
REQ-007 SHALL have ports ramREN out 1, ramWEN out 1, ramaddr out 32, ramstore out 32, ramload in 32, ramstate in 2 (ramstate_t): single shared RAM port.

Function
REQ-008 Requester "active" = its REN|WEN; REN and WEN both high SHALL be treated as a write.
REQ-009 FSM states SHALL be IDLE, XFER, RETRY.
REQ-010 IDLE: no RAM strobes; if any requester active, register owner per REQ-011, clear retry count, go XFER next cycle.
REQ-011 Owner selection SHALL be fixed priority D > V > I (see REQ-025 for alternative).
REQ-012 XFER: ramREN/ramWEN/ramaddr/ramstore SHALL combinationally follow the owner's live inputs; non-owners never reach RAM.
REQ-013 XFER, ramstate==ACCESS: owner wait=0 and owner load=ramload in that same cycle; next state IDLE.
REQ-014 XFER, ramstate FREE/BUSY: hold XFER, owner wait=1.
REQ-015 XFER, ramstate==ERROR with retry count < ERR_RETRY: increment count, go RETRY (one cycle, RAM strobes low), then XFER.
REQ-016 XFER, ramstate==ERROR with count == ERR_RETRY: owner wait=0 and owner err=1 for that single cycle; next state IDLE.
REQ-017 xwait SHALL equal active & ~(owner & completing); non-active requesters see wait=0.
REQ-018 xload SHALL be 0 unless that requester is owner and ramstate==ACCESS.
REQ-019 Owner dropping REN/WEN before completion SHALL abort: next state IDLE, no err, no wait-low pulse.
REQ-020 Minimum latency: request in cycle N, earliest completion cycle N+1; arbiter adds one IDLE cycle between back-to-back grants.
REQ-021 ramstate==ACCESS outside XFER SHALL be ignored.

Reset
REQ-022 nRST low SHALL immediately force IDLE, owner=I, retry count 0, ramREN=ramWEN=0, all err=0, all load=0.
REQ-023 Reset mid-XFER SHALL drop the access with no completion pulse; pending requesters see wait=1 after release.
REQ-024 First arbitration SHALL occur on the first rising edge after nRST deasserts.

Configuration
REQ-025 With MEM_ARBITER_RR_EN defined, selection SHALL be round-robin in order D->V->I, starting after last completed owner (reset last owner = I, so D first); without it, REQ-011 fixed priority.
REQ-026 Last-owner register SHALL update only on ACCESS or final-ERROR completion, not on abort.

Structure
REQ-027 arb_state_t (IDLE, XFER, RETRY), arb_owner_t (OWN_I, OWN_D, OWN_V) and ERR_RETRY default SHALL live in cpu_types_pkg.
REQ-028 Owner selection SHALL be sub-module arb_pick (active vector, last owner in; owner out), combinational.

Verification
REQ-029 iREN and dREN asserted together, ramstate ACCESS after 2 BUSY cycles -> dwait low cycle 3, dload=ramload; I granted after one IDLE, iwait low on its ACCESS.
REQ-030 vWEN=1, vaddr=0x100, vstore=0xDEADBEEF -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF during XFER; vwait low on ACCESS.
REQ-031 dREN, ramstate ERROR x3 with ERR_RETRY=2 -> two RETRY cycles with strobes low, third ERROR gives derr=1, dwait=0 single cycle.
REQ-032 nRST pulsed low during XFER -> ramREN/ramWEN 0 immediately, no dwait-low pulse, re-grant after release.
REQ-033 With MEM_ARBITER_RR_EN, all three active continuously -> grant order D, V, I, D; without it, D monopolises.
REQ-034 Owner drops dREN mid-XFER -> IDLE next cycle, derr=0, next requester granted.
